// File: rtl/costas_pd.sv
// Costas loop phase detector: integrate-and-dump of baseband I/Q, phase-error
// word (I*Q or sign(I)*Q) with a one-cycle strobe, and a consecutive-pass lock detector.
module costas_pd #(
  parameter int unsigned DUMP_LOG2 = 4,
  parameter int unsigned PD_MODE   = 0,
  parameter int unsigned LOCK_N    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [15:0] i_in,
  input  logic signed [15:0] q_in,
  output logic signed [15:0] i_avg,
  output logic signed [15:0] q_avg,
  output logic signed [15:0] err,
  output logic               err_valid,
  output logic               lock
);

  localparam int unsigned AW       = 16 + DUMP_LOG2;
  localparam logic [7:0]  LOCK_MAX = 8'(LOCK_N);

  logic signed [AW-1:0]    acc_i_q, acc_q_q;
  logic [DUMP_LOG2-1:0]    cnt_q;
  logic                    dump_q;
  logic signed [15:0]      i_avg_q, q_avg_q, err_q;
  logic                    err_valid_q, lock_q;
  logic [7:0]              lock_cnt_q;

  logic signed [AW-1:0]    sum_i, sum_q;
  logic                    last;
  logic signed [31:0]      prod;
  logic signed [15:0]      err_d;
  logic signed [17:0]      i_ext, q_ext;
  logic [17:0]             abs_i, abs_q;
  logic                    pass;
  logic [7:0]              lock_cnt_d;

  always_comb begin
    sum_i = acc_i_q + {{DUMP_LOG2{i_in[15]}}, i_in};
    sum_q = acc_q_q + {{DUMP_LOG2{q_in[15]}}, q_in};
    last  = (cnt_q == '1);

    prod  = i_avg_q * q_avg_q;
    err_d = '0;
    if (PD_MODE == 0) begin
      // Only (-32768)^2 reaches 2^30; every other product fits p[30:15].
      if (prod == 32'sh4000_0000) err_d = 16'sh7FFF;
      else                        err_d = prod[30:15];
    end else begin
      if (!i_avg_q[15])                err_d = q_avg_q;
      else if (q_avg_q == 16'sh8000)   err_d = 16'sh7FFF;
      else                             err_d = -q_avg_q;
    end

    i_ext = {{2{i_avg_q[15]}}, i_avg_q};
    q_ext = {{2{q_avg_q[15]}}, q_avg_q};
    abs_i = i_ext[17] ? 18'(-i_ext) : i_ext;
    abs_q = q_ext[17] ? 18'(-q_ext) : q_ext;
    pass  = abs_i > (abs_q << 1);

    lock_cnt_d = '0;
    if (pass) lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      cnt_q       <= '0;
      dump_q      <= 1'b0;
      i_avg_q     <= '0;
      q_avg_q     <= '0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
      lock_q      <= 1'b0;
      lock_cnt_q  <= '0;
    end else begin
      dump_q <= 1'b0;
      if (in_valid) begin
        if (last) begin
          // Upper 16 bits of the block sum are the floor average.
          i_avg_q <= sum_i[AW-1:DUMP_LOG2];
          q_avg_q <= sum_q[AW-1:DUMP_LOG2];
          acc_i_q <= '0;
          acc_q_q <= '0;
          cnt_q   <= '0;
          dump_q  <= 1'b1;
        end else begin
          acc_i_q <= sum_i;
          acc_q_q <= sum_q;
          cnt_q   <= cnt_q + 1'b1;
        end
      end
      err_valid_q <= dump_q;
      if (dump_q) begin
        err_q      <= err_d;
        lock_cnt_q <= lock_cnt_d;
        lock_q     <= (lock_cnt_d == LOCK_MAX);
      end
    end
  end

  assign i_avg     = i_avg_q;
  assign q_avg     = q_avg_q;
  assign err       = err_q;
  assign err_valid = err_valid_q;
  assign lock      = lock_q;

endmodule

// File: tb/tb_costas_pd.sv
// Scoreboard bench for costas_pd: two instances (product law and sign law) share
// the same stimulus; each dump pushes an expected record popped on err_valid.
module tb_costas_pd;

  localparam int unsigned LN = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic signed [15:0] i_in = '0, q_in = '0;
  logic signed [15:0] i_avg0, q_avg0, err0, i_avg1, q_avg1, err1;
  logic ev0, ev1, lock0, lock1;

  costas_pd #(.DUMP_LOG2(4), .PD_MODE(0), .LOCK_N(LN)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .i_in(i_in), .q_in(q_in),
    .i_avg(i_avg0), .q_avg(q_avg0), .err(err0), .err_valid(ev0), .lock(lock0));

  costas_pd #(.DUMP_LOG2(4), .PD_MODE(1), .LOCK_N(LN)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .i_in(i_in), .q_in(q_in),
    .i_avg(i_avg1), .q_avg(q_avg1), .err(err1), .err_valid(ev1), .lock(lock1));

  always #5 clk = ~clk;

  typedef struct {
    int ia;
    int qa;
    int e0;
    int e1;
    int lk;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0, n_errors = 0;
  int   n_push = 0, n_pop = 0;
  int   m_si = 0, m_sq = 0, m_cnt = 0, m_lock = 0;
  logic prev_ev = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Bench-side reference: floor average, error laws and lock counter.
  task automatic model_sample(input int iv, input int qv);
    exp_t   e;
    longint p;
    m_si += iv;
    m_sq += qv;
    m_cnt++;
    if (m_cnt == 16) begin
      e.ia = m_si >>> 4;
      e.qa = m_sq >>> 4;
      p = longint'(e.ia) * longint'(e.qa);
      e.e0 = (p == 64'sd1073741824) ? 32767 : int'(p >>> 15);
      e.e1 = (e.ia >= 0) ? e.qa : ((e.qa == -32768) ? 32767 : -e.qa);
      if (((e.ia < 0) ? -e.ia : e.ia) > 2 * ((e.qa < 0) ? -e.qa : e.qa))
        m_lock = (m_lock < LN) ? m_lock + 1 : m_lock;
      else
        m_lock = 0;
      e.lk = (m_lock == LN) ? 1 : 0;
      sb.push_back(e);
      n_push++;
      m_si = 0;
      m_sq = 0;
      m_cnt = 0;
    end
  endtask

  task automatic send(input int iv, input int qv, input logic v);
    @(posedge clk);
    #1;
    in_valid = v;
    i_in = 16'(iv);
    q_in = 16'(qv);
    if (v) model_sample(iv, qv);
  endtask

  task automatic block(input int iv, input int qv, input int gap);
    for (int k = 0; k < 16; k++) begin
      send(iv, qv, 1'b1);
      if (gap != 0) send(0, 0, 1'b0);
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      reset = 1'b0;
      in_valid = 1'b1;
      i_in = 16'($urandom);
      q_in = 16'($urandom);
    end
    m_si = 0;
    m_sq = 0;
    m_cnt = 0;
    m_lock = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (prev_ev) check("ev_single_cycle", int'(ev0), 0);
      if (ev0) begin
        check("ev_match", int'(ev1), 1);
        if (sb.size() == 0) begin
          check("spurious_ev", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          n_pop++;
          check("i_avg0", int'(i_avg0), e.ia);
          check("q_avg0", int'(q_avg0), e.qa);
          check("i_avg1", int'(i_avg1), e.ia);
          check("err_mode0", int'(err0), e.e0);
          check("err_mode1", int'(err1), e.e1);
          check("lock0", int'(lock0), e.lk);
          check("lock1", int'(lock1), e.lk);
        end
      end
      prev_ev <= ev0;
    end else begin
      prev_ev <= 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);
    check("rst_i_avg", int'(i_avg0), 0);
    check("rst_q_avg", int'(q_avg1), 0);
    check("rst_err0", int'(err0), 0);
    check("rst_err1", int'(err1), 0);
    check("rst_ev", int'(ev0 | ev1), 0);
    check("rst_lock", int'(lock0 | lock1), 0);
    send(0, 0, 1'b0);

    block(16384, 8192, 0);
    block(16384, 8192, 1);
    block(-32768, -32768, 0);
    block(-100, -32768, 0);
    for (int k = 0; k < 16; k++) send((k % 2 == 0) ? -1 : 0, 0, 1'b1);
    block(-100, 5000, 0);
    for (int d = 0; d < 4; d++) block(20000, 1000, 0);
    block(20000, 1000, 0);
    block(20000, 20000, 0);
    for (int d = 0; d < 2; d++) block(20000, 1000, 0);

    for (int k = 0; k < 7; k++) send(32767, 32767, 1'b1);
    send(0, 0, 1'b0);
    send(0, 0, 1'b0);
    do_reset(1);
    block(0, 0, 0);

    for (int d = 0; d < 4; d++)
      for (int k = 0; k < 16; k++) begin
        send(int'($signed(16'($urandom))), int'($signed(16'($urandom))), 1'b1);
        if ($urandom_range(0, 3) == 0) send(0, 0, 1'b0);
      end

    send(0, 0, 1'b0);
    for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    check("dump_count", n_pop, n_push);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
